t08_lcd_arbiter: RTL and testbench
==================================

T08_LCD_ARBITER -- requirements
Module: t08_lcd_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8: max cycles spi_enable is held waiting for spi_busy to rise.
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req0, req1  in  1 each  transfer request from requester 0 (CPU MMIO) and requester 1 (graphics).
REQ-005 cmd0, cmd1  in  8 each  LCD command byte.
REQ-006 par0, par1  in  32 each  parameter bytes, MSB byte sent first.
REQ-007 cnt0, cnt1  in  4 each  parameter byte count, legal range 0..4.
REQ-008 rw0, rw1  in  1 each  readwrite flag passed to the engine.
REQ-009 ack0, ack1  out  1 each  one-cycle completion pulse to the owning requester.
REQ-010 spi_enable  out  1  start/hold strobe to the LCD engine.
REQ-011 spi_command, spi_parameters, spi_counter, spi_readwrite  out  8/32/4/1  latched payload to the engine.
REQ-012 spi_busy  in  1  engine busy status.
REQ-013 arb_busy  out  1  high whenever the FSM is not IDLE.
REQ-014 timeout_err  out  1  one-cycle pulse when the engine never asserted spi_busy.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT_DONE, ACK.
REQ-016 IDLE: if any req is high, select a winner, latch its cmd/par/cnt/rw into the spi_* registers, record the owner, go to ISSUE next cycle.
REQ-017 Default arbitration is round-robin: on simultaneous req0 and req1, grant the requester not granted last; after reset, req0 wins first.
REQ-018 Latched cnt values greater than 4 are clamped to 4; cnt = 0 issues a command-only transfer.
REQ-019 ISSUE: spi_enable = 1 and a wait counter increments each cycle. When spi_busy = 1, go to WAIT_DONE with spi_enable = 0.
REQ-020 In ISSUE, if the counter reaches TIMEOUT without spi_busy, drop spi_enable, pulse timeout_err, and go to ACK.
REQ-021 WAIT_DONE: hold the payload stable and keep spi_enable = 0. On the first cycle with spi_busy = 0, go to ACK.
REQ-022 ACK: pulse ack of the owner for exactly one cycle, then go to IDLE. A req still high is treated as a new request one cycle later.
REQ-023 The spi_* payload changes only on the IDLE->ISSUE transition. Requester inputs are ignored while arb_busy = 1.
REQ-024 Latency: from req rising in IDLE, spi_enable rises 1 cycle later. The ack pulse comes 1 cycle after spi_busy falls.
REQ-025 A requester dropping req mid-transfer does not abort the transfer; its ack still pulses.
REQ-026 Total latency is at most TIMEOUT + 2 cycles when the engine never responds.

Reset
REQ-027 On rst = 1 at a clock edge: state = IDLE and the round-robin pointer selects req0 next.
REQ-028 On the same edge, all outputs go to 0: spi_enable, spi_command, spi_parameters, spi_counter, spi_readwrite, ack0, ack1, arb_busy and timeout_err.
REQ-029 rst mid-transfer drops spi_enable on the same edge and produces no ack.

Configuration
REQ-030 Macro T08_LCD_ARB_PRIORITY_EN, when defined: fixed priority, req0 always wins ties and the round-robin pointer is removed.
REQ-031 When the macro is not defined, the round-robin arbitration of REQ-017 applies.

Verification
REQ-032 Single request: req0 = 1, cmd0 = 8'h2A, par0 = 32'h0000_00EF, cnt0 = 4, engine busy for 10 cycles. Required: spi_enable rises 1 cycle after req0; spi_command = 8'h2A; ack0 pulses once, 1 cycle after busy falls.
REQ-033 Tie: req0 and req1 both high continuously, cmd0 = 8'h2B, cmd1 = 8'h2C. Required: grants alternate 2B, 2C, 2B; with T08_LCD_ARB_PRIORITY_EN defined, only 2B is issued.
REQ-034 Dead engine: spi_busy tied to 0, req1 = 1. Required: spi_enable is high for exactly 8 cycles, then timeout_err and ack1 each pulse once.
REQ-035 Clamp: cnt0 = 4'd9, par0 = 32'hAABB_CCDD. Required: spi_counter = 4 and spi_parameters = 32'hAABB_CCDD.
REQ-036 Reset mid-transfer: rst asserted during WAIT_DONE. Required: all outputs are 0 on the next edge, no ack, and req1 is served first after reset only if req0 is low.
REQ-037 Payload stability: cmd0 changes from 8'h29 to 8'h2E while WAIT_DONE. Required: spi_command stays 8'h29 until ack0.

Source files
------------

// File: rtl/t08_lcd_arbiter.sv
// Purpose: arbitrates two LCD transfer requesters (CPU MMIO, graphics) onto one SPI LCD engine.
// Latency: spi_enable 1 cycle after req in IDLE; ack 1 cycle after spi_busy falls; TIMEOUT edges worst case.
// Backpressure: requests are ignored while arb_busy; optional macro T08_LCD_ARB_PRIORITY_EN selects fixed priority.
module t08_lcd_arbiter #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  cmd0,
    input  logic [7:0]  cmd1,
    input  logic [31:0] par0,
    input  logic [31:0] par1,
    input  logic [3:0]  cnt0,
    input  logic [3:0]  cnt1,
    input  logic        rw0,
    input  logic        rw1,
    output logic        ack0,
    output logic        ack1,
    output logic        spi_enable,
    output logic [7:0]  spi_command,
    output logic [31:0] spi_parameters,
    output logic [3:0]  spi_counter,
    output logic        spi_readwrite,
    input  logic        spi_busy,
    output logic        arb_busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic            owner;        // 0: requester 0 owns the transfer, 1: requester 1
    logic            timed_out;
    logic            start;
    logic            grant1;
    logic            timeout_hit;

`ifndef T08_LCD_ARB_PRIORITY_EN
    logic            rr_prefer1;   // set after a req0 grant so req1 wins the next tie
`endif

    // Winner selection: fixed priority or round-robin on ties
    always_comb begin
        grant1 = 1'b0;
`ifdef T08_LCD_ARB_PRIORITY_EN
        grant1 = !req0 && req1;
`else
        grant1 = req1 && (!req0 || rr_prefer1);
`endif
    end

    // Next-state logic; the engine is given TIMEOUT cycles of spi_enable to respond
    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    start     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (spi_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ACK;
                end
            end
            WAIT_DONE: begin
                if (!spi_busy) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Payload capture on grant, wait counter and timeout flag; payload only moves on IDLE->ISSUE
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_command    <= 8'd0;
            spi_parameters <= 32'd0;
            spi_counter    <= 4'd0;
            spi_readwrite  <= 1'b0;
            owner          <= 1'b0;
            wait_cnt       <= '0;
            timed_out      <= 1'b0;
        end else if (start) begin
            spi_command    <= grant1 ? cmd1 : cmd0;
            spi_parameters <= grant1 ? par1 : par0;
            spi_counter    <= grant1 ? ((cnt1 > 4'd4) ? 4'd4 : cnt1)
                                     : ((cnt0 > 4'd4) ? 4'd4 : cnt0);
            spi_readwrite  <= grant1 ? rw1 : rw0;
            owner          <= grant1;
            wait_cnt       <= '0;
            timed_out      <= 1'b0;
        end else if (state == ISSUE) begin
            wait_cnt <= wait_cnt + CW'(1);
            if (timeout_hit) begin
                timed_out <= 1'b1;
            end
        end
    end

`ifndef T08_LCD_ARB_PRIORITY_EN
    // Round-robin pointer: after reset req0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_prefer1 <= 1'b0;
        end else if (start) begin
            rr_prefer1 <= !grant1;
        end
    end
`endif

    // Outputs decoded from registered state so reset clears them on the same edge
    always_comb begin
        spi_enable  = (state == ISSUE);
        arb_busy    = (state != IDLE);
        ack0        = (state == ACK) && !owner;
        ack1        = (state == ACK) && owner;
        timeout_err = (state == ACK) && timed_out;
    end

endmodule

// File: tb/tb_t08_lcd_arbiter.sv
// Purpose: self-checking bench for t08_lcd_arbiter with a simple SPI engine model and scoreboard.
// Latency: checks enable/ack timing relative to req and spi_busy.
// Backpressure: engine model holds spi_busy for a programmable number of cycles or never responds.
module tb_t08_lcd_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [7:0]  cmd0, cmd1;
    logic [31:0] par0, par1;
    logic [3:0]  cnt0, cnt1;
    logic        rw0, rw1;
    logic        ack0, ack1;
    logic        spi_enable;
    logic [7:0]  spi_command;
    logic [31:0] spi_parameters;
    logic [3:0]  spi_counter;
    logic        spi_readwrite;
    logic        spi_busy;
    logic        arb_busy;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] par;
        logic [3:0]  cnt;
        logic        rw;
    } iss_t;

    typedef struct {
        logic owner;
        logic to;
    } ack_t;

    iss_t exp_iss[$];
    ack_t exp_ack[$];
    iss_t mon_e;
    ack_t mon_a;
    logic en_q = 1'b0;

    logic engine_on = 1'b0;
    int   busy_len  = 1;
    int   eng_cnt   = 0;

    t08_lcd_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .cmd0(cmd0), .cmd1(cmd1),
        .par0(par0), .par1(par1),
        .cnt0(cnt0), .cnt1(cnt1),
        .rw0(rw0), .rw1(rw1),
        .ack0(ack0), .ack1(ack1),
        .spi_enable(spi_enable),
        .spi_command(spi_command),
        .spi_parameters(spi_parameters),
        .spi_counter(spi_counter),
        .spi_readwrite(spi_readwrite),
        .spi_busy(spi_busy),
        .arb_busy(arb_busy),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine model: goes busy one cycle after seeing spi_enable, stays busy busy_len cycles
    initial begin
        spi_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!engine_on || rst) begin
                spi_busy = 1'b0;
            end else if (spi_busy) begin
                if (eng_cnt <= 1) spi_busy = 1'b0;
                else eng_cnt = eng_cnt - 1;
            end else if (spi_enable) begin
                spi_busy = 1'b1;
                eng_cnt  = busy_len;
            end
        end
    end

    // Scoreboard: payload compared on each spi_enable rise, owner/timeout compared on each ack
    always @(negedge clk) begin
        if (!rst) begin
            if (spi_enable && !en_q) begin
                tests++;
                if (exp_iss.size() == 0) begin
                    fails++;
                    $display("FAIL sb_issue: unexpected issue cmd=%h", spi_command);
                end else begin
                    mon_e = exp_iss.pop_front();
                    if ({spi_command, spi_parameters, spi_counter, spi_readwrite} !==
                        {mon_e.cmd, mon_e.par, mon_e.cnt, mon_e.rw}) begin
                        fails++;
                        $display("FAIL sb_issue: got cmd=%h par=%h cnt=%0d rw=%b want cmd=%h par=%h cnt=%0d rw=%b",
                                 spi_command, spi_parameters, spi_counter, spi_readwrite,
                                 mon_e.cmd, mon_e.par, mon_e.cnt, mon_e.rw);
                    end
                end
            end
            if (ack0 || ack1) begin
                tests++;
                if (exp_ack.size() == 0) begin
                    fails++;
                    $display("FAIL sb_ack: unexpected ack0=%b ack1=%b", ack0, ack1);
                end else begin
                    mon_a = exp_ack.pop_front();
                    if ({ack1, ack0, timeout_err} !== {mon_a.owner, !mon_a.owner, mon_a.to}) begin
                        fails++;
                        $display("FAIL sb_ack: got ack1=%b ack0=%b to=%b want owner=%b to=%b",
                                 ack1, ack0, timeout_err, mon_a.owner, mon_a.to);
                    end
                end
            end
        end
        en_q = spi_enable;
    end

    task automatic push_iss(input logic [7:0] c, input logic [31:0] p, input logic [3:0] n, input logic r);
        iss_t e;
        e.cmd = c; e.par = p; e.cnt = n; e.rw = r;
        exp_iss.push_back(e);
    endtask

    task automatic push_ack(input logic o, input logic t);
        ack_t a;
        a.owner = o; a.to = t;
        exp_ack.push_back(a);
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        cmd0 = 8'hFF; cmd1 = 8'hFF; par0 = '1; par1 = '1;
        cnt0 = 4'hF; cnt1 = 4'hF; rw0 = 1'b1; rw1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if ({spi_enable, spi_command, spi_parameters, spi_counter, spi_readwrite,
             ack0, ack1, arb_busy, timeout_err} !== 50'd0) begin
            fails++;
            $display("FAIL reset_outputs: en=%b cmd=%h par=%h cnt=%h rw=%b ack=%b%b busy=%b to=%b want all 0",
                     spi_enable, spi_command, spi_parameters, spi_counter, spi_readwrite,
                     ack1, ack0, arb_busy, timeout_err);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (arb_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: arb_busy=%b want 0", arb_busy);
        end
    endtask

    task automatic test_single();
        int n;
        apply_reset();
        engine_on = 1'b1; busy_len = 10;
        push_iss(8'h2A, 32'h0000_00EF, 4'd4, 1'b0);
        push_ack(1'b0, 1'b0);
        @(posedge clk); #1;
        req0 = 1'b1; cmd0 = 8'h2A; par0 = 32'h0000_00EF; cnt0 = 4'd4; rw0 = 1'b0;
        @(negedge clk);
        tests++;
        if (spi_enable !== 1'b0) begin
            fails++;
            $display("FAIL single_en_early: spi_enable=%b want 0", spi_enable);
        end
        @(negedge clk);
        tests++;
        if (spi_enable !== 1'b1 || spi_command !== 8'h2A) begin
            fails++;
            $display("FAIL single_en_latency: spi_enable=%b cmd=%h want 1 2a", spi_enable, spi_command);
        end
        req0 = 1'b0;
        n = 0;
        while (!spi_busy && n < 20) begin @(negedge clk); n++; end
        while (spi_busy && n < 40) begin @(negedge clk); n++; end
        tests++;
        if (n >= 40 || ack0 !== 1'b0) begin
            fails++;
            $display("FAIL single_busy_fall: n=%0d ack0=%b want busy cycle then ack0 0", n, ack0);
        end
        @(negedge clk);
        tests++;
        if (ack0 !== 1'b1 || spi_command !== 8'h2A) begin
            fails++;
            $display("FAIL single_ack: ack0=%b cmd=%h want 1 2a", ack0, spi_command);
        end
        @(negedge clk);
        tests++;
        if (ack0 !== 1'b0 || arb_busy !== 1'b0) begin
            fails++;
            $display("FAIL single_ack_once: ack0=%b arb_busy=%b want 0 0", ack0, arb_busy);
        end
    endtask

    task automatic test_tie();
        int n;
        int acks;
        apply_reset();
        engine_on = 1'b1; busy_len = 2;
`ifdef T08_LCD_ARB_PRIORITY_EN
        push_iss(8'h2B, 32'h1111_1111, 4'd1, 1'b0); push_ack(1'b0, 1'b0);
        push_iss(8'h2B, 32'h1111_1111, 4'd1, 1'b0); push_ack(1'b0, 1'b0);
        push_iss(8'h2B, 32'h1111_1111, 4'd1, 1'b0); push_ack(1'b0, 1'b0);
`else
        push_iss(8'h2B, 32'h1111_1111, 4'd1, 1'b0); push_ack(1'b0, 1'b0);
        push_iss(8'h2C, 32'h2222_2222, 4'd2, 1'b1); push_ack(1'b1, 1'b0);
        push_iss(8'h2B, 32'h1111_1111, 4'd1, 1'b0); push_ack(1'b0, 1'b0);
`endif
        @(posedge clk); #1;
        req0 = 1'b1; cmd0 = 8'h2B; par0 = 32'h1111_1111; cnt0 = 4'd1; rw0 = 1'b0;
        req1 = 1'b1; cmd1 = 8'h2C; par1 = 32'h2222_2222; cnt1 = 4'd2; rw1 = 1'b1;
        n = 0; acks = 0;
        while (acks < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (ack0 || ack1) acks++;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (acks != 3 || exp_iss.size() != 0 || exp_ack.size() != 0 || arb_busy !== 1'b0) begin
            fails++;
            $display("FAIL tie_count: acks=%0d pending_iss=%0d pending_ack=%0d busy=%b want 3 0 0 0",
                     acks, exp_iss.size(), exp_ack.size(), arb_busy);
        end
    endtask

    task automatic test_dead_engine();
        int hi;
        apply_reset();
        engine_on = 1'b0;
        push_iss(8'h11, 32'h1234_5678, 4'd2, 1'b1);
        push_ack(1'b1, 1'b1);
        @(posedge clk); #1;
        req1 = 1'b1; cmd1 = 8'h11; par1 = 32'h1234_5678; cnt1 = 4'd2; rw1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        hi = 0;
        while (spi_enable && hi < 40) begin
            hi++;
            req1 = 1'b0;
            @(negedge clk);
        end
        tests++;
        if (hi != 8) begin
            fails++;
            $display("FAIL dead_enable_len: spi_enable high %0d cycles want 8", hi);
        end
        tests++;
        if ({ack1, ack0, timeout_err} !== 3'b101) begin
            fails++;
            $display("FAIL dead_pulse: ack1=%b ack0=%b to=%b want 1 0 1", ack1, ack0, timeout_err);
        end
        @(negedge clk);
        tests++;
        if ({ack1, timeout_err, arb_busy} !== 3'b000) begin
            fails++;
            $display("FAIL dead_pulse_once: ack1=%b to=%b busy=%b want 0 0 0", ack1, timeout_err, arb_busy);
        end
    endtask

    task automatic test_clamp();
        int n;
        apply_reset();
        engine_on = 1'b1; busy_len = 3;
        push_iss(8'h2C, 32'hAABB_CCDD, 4'd4, 1'b0);
        push_ack(1'b0, 1'b0);
        @(posedge clk); #1;
        req0 = 1'b1; cmd0 = 8'h2C; par0 = 32'hAABB_CCDD; cnt0 = 4'd9; rw0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (spi_counter !== 4'd4 || spi_parameters !== 32'hAABB_CCDD) begin
            fails++;
            $display("FAIL clamp: cnt=%0d par=%h want 4 aabbccdd", spi_counter, spi_parameters);
        end
        req0 = 1'b0;
        n = 0;
        while (arb_busy && n < 50) begin @(negedge clk); n++; end
        tests++;
        if (arb_busy !== 1'b0) begin
            fails++;
            $display("FAIL clamp_done: arb_busy=%b want 0", arb_busy);
        end
    endtask

    task automatic test_payload_stable();
        int n;
        apply_reset();
        engine_on = 1'b1; busy_len = 6;
        push_iss(8'h29, 32'h0000_0000, 4'd0, 1'b0);
        push_ack(1'b0, 1'b0);
        @(posedge clk); #1;
        req0 = 1'b1; cmd0 = 8'h29; par0 = 32'h0; cnt0 = 4'd0; rw0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req0 = 1'b0;
        n = 0;
        while (!spi_busy && n < 20) begin @(negedge clk); n++; end
        cmd0 = 8'h2E;
        while (!ack0 && n < 60) begin
            @(negedge clk);
            n++;
            tests++;
            if (spi_command !== 8'h29) begin
                fails++;
                $display("FAIL payload_stable: spi_command=%h want 29", spi_command);
            end
        end
        tests++;
        if (ack0 !== 1'b1) begin
            fails++;
            $display("FAIL payload_ack: ack0=%b want 1 (timeout n=%0d)", ack0, n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        engine_on = 1'b1; busy_len = 10;
        push_iss(8'h2B, 32'h0000_0001, 4'd1, 1'b0);
        @(posedge clk); #1;
        req0 = 1'b1; cmd0 = 8'h2B; par0 = 32'h1; cnt0 = 4'd1; rw0 = 1'b0;
        req1 = 1'b0; cmd1 = 8'h2C; par1 = 32'h2; cnt1 = 4'd1; rw1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req0 = 1'b0;
        n = 0;
        while (!spi_busy && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        tests++;
        if (spi_enable !== 1'b0 || arb_busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_wait: en=%b busy=%b want 0 1", spi_enable, arb_busy);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({spi_enable, spi_command, spi_parameters, spi_counter, spi_readwrite,
             ack0, ack1, arb_busy, timeout_err} !== 50'd0) begin
            fails++;
            $display("FAIL rstmid_outputs: en=%b cmd=%h par=%h cnt=%h ack=%b%b busy=%b to=%b want all 0",
                     spi_enable, spi_command, spi_parameters, spi_counter, ack1, ack0, arb_busy, timeout_err);
        end
        @(negedge clk);
        // Both requesters high: the pointer must be back on req0 even though req0 was granted last
        push_iss(8'h2B, 32'h0000_0001, 4'd1, 1'b0);
        push_ack(1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        n = 0;
        while (arb_busy && n < 50) begin @(negedge clk); n++; end
        push_iss(8'h2C, 32'h0000_0002, 4'd1, 1'b1);
        push_ack(1'b1, 1'b0);
        @(posedge clk); #1;
        req1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req1 = 1'b0;
        n = 0;
        while (arb_busy && n < 50) begin @(negedge clk); n++; end
        tests++;
        if (arb_busy !== 1'b0 || exp_iss.size() != 0 || exp_ack.size() != 0) begin
            fails++;
            $display("FAIL rstmid_after: busy=%b pending_iss=%0d pending_ack=%0d want 0 0 0",
                     arb_busy, exp_iss.size(), exp_ack.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        cmd0 = '0; cmd1 = '0; par0 = '0; par1 = '0;
        cnt0 = '0; cnt1 = '0; rw0 = 1'b0; rw1 = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_dead_engine();
        test_clamp();
        test_payload_stable();
        test_reset_mid();
        repeat (3) @(negedge clk);
        tests++;
        if (exp_iss.size() != 0 || exp_ack.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: pending_iss=%0d pending_ack=%0d want 0 0", exp_iss.size(), exp_ack.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
